// File: rtl/niosmp_debug_scan_bridge.sv
// Debug scan bridge: JTAG-style virtual DR shift chain feeding a one-hot
// action handshake, with sticky short-scan/overrun status on ir_out.
module niosmp_debug_scan_bridge #(
  parameter int unsigned DR_W = 38,
  parameter int unsigned IR_W = 2,
  parameter int unsigned NCH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IR_W-1:0]     ir_in,
  input  logic                vs_uir,
  input  logic                vs_cdr,
  input  logic                vs_sdr,
  input  logic                vs_udr,
  input  logic                tdi,
  input  logic [NCH*DR_W-1:0] cap_data,
  input  logic                act_ack,
  input  logic                clr_status,
  output logic                tdo,
  output logic [DR_W-1:0]     jdo,
  output logic [NCH-1:0]      act_valid,
  output logic                act_take,
  output logic [IR_W-1:0]     ir_out
);

  localparam int unsigned CNT_W = $clog2(DR_W + 1);

  typedef enum logic [1:0] {IDLE, SCAN, PEND, PEND_SCAN} state_t;

  state_t             state;
  state_t             state_a;
  logic [IR_W-1:0]    ir_q;
  logic [DR_W-1:0]    sr;
  logic [CNT_W-1:0]   bitcnt;
  logic               short_scan;
  logic               overrun;

  logic               ack_hit;
  logic               full;
  logic               ch_ok;
  logic               pending_a;
  logic               scanning_a;
  logic [DR_W-1:0]    cap_word;
  logic [NCH-1:0]     ch_onehot;

  // Channel decode of ir_q; out-of-range instructions select nothing.
  always_comb begin
    cap_word  = '0;
    ch_onehot = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ir_q == IR_W'(k)) begin
        cap_word     = cap_data[k*DR_W +: DR_W];
        ch_onehot[k] = 1'b1;
      end
    end
  end

  // An ack retires the pending action before any strobe in the same cycle is judged.
  always_comb begin
    state_a = state;
    if (ack_hit) state_a = (state == PEND) ? IDLE : SCAN;
  end

  assign ack_hit    = act_ack && (state == PEND || state == PEND_SCAN);
  assign pending_a  = (state_a == PEND) || (state_a == PEND_SCAN);
  assign scanning_a = (state_a == SCAN) || (state_a == PEND_SCAN);
  assign full       = (bitcnt == CNT_W'(DR_W));
  assign ch_ok      = |ch_onehot;
  assign tdo        = sr[0];
  assign ir_out     = IR_W'({short_scan, overrun});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ir_q       <= '0;
      sr         <= '0;
      bitcnt     <= '0;
      jdo        <= '0;
      act_valid  <= '0;
      act_take   <= 1'b0;
      short_scan <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_a;
      if (ack_hit) act_valid <= '0;
      if (clr_status) begin
        short_scan <= 1'b0;
        overrun    <= 1'b0;
      end
      // Strobe priority: uir > cdr > udr > sdr; flag sets below override clr_status.
      if (vs_uir) begin
        ir_q <= ir_in;
      end else if (vs_cdr) begin
        sr     <= cap_word;
        bitcnt <= '0;
        state  <= pending_a ? PEND_SCAN : SCAN;
      end else if (vs_udr) begin
        if (state_a == SCAN) begin
          if (full) begin
            jdo       <= sr;
            act_take  <= sr[DR_W-1];
            act_valid <= ch_onehot;
            state     <= ch_ok ? PEND : IDLE;
          end else begin
            short_scan <= 1'b1;
            state      <= IDLE;
          end
        end else if (state_a == PEND_SCAN) begin
          overrun <= 1'b1;
          state   <= PEND;
        end
      end else if (vs_sdr && scanning_a) begin
        sr <= {tdi, sr[DR_W-1:1]};
        if (!full) bitcnt <= bitcnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_niosmp_debug_scan_bridge.sv
// Directed bench for niosmp_debug_scan_bridge: a vector table for the reset and
// strobe-priority basics, then hand sequences for scans, pending and reset cases.
module tb_niosmp_debug_scan_bridge;

  localparam int unsigned DR_W = 38;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        ir_in = '0;
  logic              vs_uir = 0, vs_cdr = 0, vs_sdr = 0, vs_udr = 0, tdi = 0;
  logic [4*DR_W-1:0] cap_data;
  logic              act_ack = 0, clr_status = 0;

  logic              tdo, act_take;
  logic [DR_W-1:0]   jdo;
  logic [3:0]        act_valid;
  logic [1:0]        ir_out;

  logic              tdo3, act_take3;
  logic [DR_W-1:0]   jdo3;
  logic [2:0]        act_valid3;
  logic [1:0]        ir_out3;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [DR_W-1:0] CAP0 = 38'h01_2345_6789;
  localparam logic [DR_W-1:0] CAP1 = 38'h15_5555_AAAA;
  localparam logic [DR_W-1:0] CAP2 = 38'h2_0000_00AB;
  localparam logic [DR_W-1:0] CAP3 = 38'h3_FFFF_0001;
  localparam logic [DR_W-1:0] W1   = 38'h2A_5A5A_A5C3;
  localparam logic [DR_W-1:0] W2   = 38'h11_1111_1111;
  localparam logic [DR_W-1:0] W3   = 38'h3F_0000_FFFF;
  localparam logic [DR_W-1:0] W4   = 38'h0F_0F0F_0F0F;
  localparam logic [DR_W-1:0] W5   = 38'h33_CCCC_3333;

  assign cap_data = {CAP3, CAP2, CAP1, CAP0};

  niosmp_debug_scan_bridge #(.DR_W(DR_W), .IR_W(2), .NCH(4)) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi),
    .cap_data(cap_data), .act_ack(act_ack), .clr_status(clr_status),
    .tdo(tdo), .jdo(jdo), .act_valid(act_valid), .act_take(act_take), .ir_out(ir_out)
  );

  niosmp_debug_scan_bridge #(.DR_W(DR_W), .IR_W(2), .NCH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi),
    .cap_data(cap_data[3*DR_W-1:0]), .act_ack(act_ack), .clr_status(clr_status),
    .tdo(tdo3), .jdo(jdo3), .act_valid(act_valid3), .act_take(act_take3), .ir_out(ir_out3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst_n, uir, cdr, udr, sdr, t, ack, clr;
    logic [1:0]      ir;
    logic            e_tdo;
    logic [3:0]      e_av;
    logic [1:0]      e_irout;
    logic [DR_W-1:0] e_jdo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic uir, cdr, udr, sdr, t, ack, clr);
    vs_uir = uir; vs_cdr = cdr; vs_udr = udr; vs_sdr = sdr; tdi = t;
    act_ack = ack; clr_status = clr;
    @(posedge clk);
    #1;
    vs_uir = 0; vs_cdr = 0; vs_udr = 0; vs_sdr = 0; tdi = 0;
    act_ack = 0; clr_status = 0;
  endtask

  // Shift n bits of w LSB-first; after shift i the capture bit i+1 should be on tdo.
  task automatic shift_word(input logic [DR_W-1:0] w, input int n,
                            input logic [DR_W-1:0] cap, input bit chk_tdo);
    logic exp;
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 1, w[i], 0, 0);
      exp = (i + 1 < int'(DR_W)) ? cap[i+1] : w[0];
      if (chk_tdo) chk("shift_tdo", 64'(tdo), 64'(exp));
    end
  endtask

  initial begin
    //            rst uir cdr udr sdr t  ack clr ir    tdo av       irout  jdo
    tbl[0] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd2, 1'b0,4'b0000,2'b00,'0};
    tbl[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,4'b0000,2'b00,'0};
    tbl[2] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0, 1'b0,4'b0000,2'b00,'0};
    tbl[3] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0, 1'b0,4'b0000,2'b00,'0};
    tbl[4] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2, 1'b0,4'b0000,2'b00,'0};
    tbl[5] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd2, 1'b1,4'b0000,2'b00,'0};
    tbl[6] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd2, 1'b1,4'b0000,2'b10,'0};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2, 1'b1,4'b0000,2'b00,'0};
    tbl[8] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2, 1'b1,4'b0000,2'b00,'0};

    @(posedge clk); #1;
    for (int r = 0; r < 9; r++) begin
      reset_n = tbl[r].rst_n;
      ir_in   = tbl[r].ir;
      cyc(tbl[r].uir, tbl[r].cdr, tbl[r].udr, tbl[r].sdr, tbl[r].t, tbl[r].ack, tbl[r].clr);
      chk($sformatf("vec%0d_tdo", r),   64'(tdo),       64'(tbl[r].e_tdo));
      chk($sformatf("vec%0d_av", r),    64'(act_valid), 64'(tbl[r].e_av));
      chk($sformatf("vec%0d_irout", r), 64'(ir_out),    64'(tbl[r].e_irout));
      chk($sformatf("vec%0d_jdo", r),   64'(jdo),       64'(tbl[r].e_jdo));
    end
    reset_n = 1'b1;

    // Full scan on channel 2 producing an action.
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("cap2_tdo", 64'(tdo), 64'(CAP2[0]));
    shift_word(W1, 38, CAP2, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("act_av", 64'(act_valid), 64'(4'b0100));
    chk("act_jdo", 64'(jdo), 64'(W1));
    chk("act_take", 64'(act_take), 64'(1'b1));
    chk("act_irout", 64'(ir_out), 64'(2'b00));

    // Second full scan while pending: overrun, outputs held.
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("pscan_av", 64'(act_valid), 64'(4'b0100));
    chk("pscan_tdo", 64'(tdo), 64'(CAP2[0]));
    shift_word(W2, 38, CAP2, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("ovr_irout", 64'(ir_out), 64'(2'b01));
    chk("ovr_jdo", 64'(jdo), 64'(W1));
    chk("ovr_av", 64'(act_valid), 64'(4'b0100));
    chk("ovr_take", 64'(act_take), 64'(1'b1));
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ack_av", 64'(act_valid), 64'(4'b0000));
    cyc(0, 0, 0, 1, ~W2[0], 0, 0);
    chk("idle_sdr_tdo", 64'(tdo), 64'(W2[0]));
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("idle_udr_irout", 64'(ir_out), 64'(2'b01));
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("clr_irout", 64'(ir_out), 64'(2'b00));

    // Short scan (37 bits).
    cyc(0, 1, 0, 0, 0, 0, 0);
    shift_word(W3, 37, CAP2, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("short_av", 64'(act_valid), 64'(4'b0000));
    chk("short_irout", 64'(ir_out), 64'(2'b10));
    chk("short_jdo", 64'(jdo), 64'(W1));
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("short_clr", 64'(ir_out), 64'(2'b00));
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1);
    chk("set_beats_clr", 64'(ir_out), 64'(2'b10));
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("clr_again", 64'(ir_out), 64'(2'b00));

    // Back-to-back action: ack and full udr together in PEND_SCAN.
    cyc(0, 1, 0, 0, 0, 0, 0);
    shift_word(W3, 38, CAP2, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("b2b_av1", 64'(act_valid), 64'(4'b0100));
    chk("b2b_jdo1", 64'(jdo), 64'(W3));
    ir_in = 2'd1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("uir_pend_av", 64'(act_valid), 64'(4'b0100));
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("cap1_tdo", 64'(tdo), 64'(CAP1[0]));
    shift_word(W4, 38, CAP1, 1);
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("b2b_av2", 64'(act_valid), 64'(4'b0010));
    chk("b2b_jdo2", 64'(jdo), 64'(W4));
    chk("b2b_take2", 64'(act_take), 64'(1'b0));
    chk("b2b_irout", 64'(ir_out), 64'(2'b00));
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("b2b_ack", 64'(act_valid), 64'(4'b0000));

    // Reset mid-shift, with a udr strobe held during reset.
    ir_in = 2'd0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    shift_word(W1, 20, CAP0, 1);
    reset_n = 1'b0;
    cyc(0, 0, 1, 0, 0, 0, 0);
    reset_n = 1'b1;
    chk("rst_tdo", 64'(tdo), 64'(1'b0));
    chk("rst_jdo", 64'(jdo), 64'(0));
    chk("rst_av", 64'(act_valid), 64'(4'b0000));
    chk("rst_take", 64'(act_take), 64'(1'b0));
    chk("rst_irout", 64'(ir_out), 64'(2'b00));
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("rst_udr_av", 64'(act_valid), 64'(4'b0000));
    chk("rst_udr_irout", 64'(ir_out), 64'(2'b00));

    // Reset while an action is pending.
    cyc(0, 1, 0, 0, 0, 0, 0);
    shift_word(W1, 38, CAP0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("ch0_av", 64'(act_valid), 64'(4'b0001));
    reset_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    chk("rst_pend_av", 64'(act_valid), 64'(4'b0000));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_pend_av2", 64'(act_valid), 64'(4'b0000));

    // ir_q beyond NCH on the 3-channel instance; ch3 is real on the 4-channel one.
    ir_in = 2'd3;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("nch3_cap_tdo", 64'(tdo3), 64'(1'b0));
    chk("ch3_cap_tdo", 64'(tdo), 64'(CAP3[0]));
    shift_word(W5, 38, CAP3, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("nch3_jdo", 64'(jdo3), 64'(W5));
    chk("nch3_av", 64'(act_valid3), 64'(3'b000));
    chk("nch3_take", 64'(act_take3), 64'(1'b1));
    chk("ch3_av", 64'(act_valid), 64'(4'b1000));
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("nch3_idle_tdo", 64'(tdo3), 64'(W5[0]));
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("nch3_idle_irout", 64'(ir_out3), 64'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
